bert_test_sequencer: RTL and testbench

Controller that runs one complete bit-error-ratio measurement on the PRBS/channel datapath.
- Pulses the channel reset to the test_control datapath.
- Waits for the checker to report sustained error-free words, which indicates PRBS sync.
- Accumulates error bits and bit totals over a programmable window of words, then reports done.
- Sits between the host/config logic and the test_control datapath; consumes its per-word error vector.

---
 rtl/bert_test_sequencer.sv | 165 ++++++++++++++++
 tb/tb_bert_test_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bert_test_sequencer.sv
// Runs one bit-error-ratio measurement: channel reset, PRBS sync, windowed error accumulation.
// Every output is a register; state is exported with the encoding IDLE=0..DONE=4.
module bert_test_sequencer #(
  parameter int unsigned DW           = 8,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned SYNC_WORDS   = 16,
  parameter int unsigned SYNC_TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] window_words,
  input  logic [CNT_W-1:0] err_threshold,
  input  logic             word_valid,
  input  logic [DW-1:0]    error,
  output logic             channel_reset,
  output logic             busy,
  output logic             done,
  output logic             sync_fail,
  output logic             threshold_exceeded,
  output logic [CNT_W-1:0] total_errors,
  output logic [CNT_W-1:0] total_bits,
  output logic [2:0]       state
);

  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned SR_W  = $clog2(SYNC_WORDS + 1);
  localparam int unsigned TO_W  = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned PC_W  = $clog2(DW + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHRST   = 3'd1,
    S_SYNC    = 3'd2,
    S_MEASURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           st;
  logic [RST_W-1:0] rst_cnt;
  logic [SR_W-1:0]  sync_run;
  logic [TO_W-1:0]  sync_cyc;
  logic [CNT_W-1:0] words_seen;
  logic [CNT_W-1:0] window_q;
  logic [CNT_W-1:0] thresh_q;

  function automatic logic [PC_W-1:0] popcount(input logic [DW-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(DW); i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  logic [SUM_W-1:0] err_sum;
  logic [SUM_W-1:0] bit_sum;
  logic             clean_word;
  logic             sync_hit;

  assign err_sum    = {1'b0, total_errors} + SUM_W'(popcount(error));
  assign bit_sum    = {1'b0, total_bits} + SUM_W'(DW);
  assign clean_word = word_valid && (error == '0);
  assign sync_hit   = clean_word && (sync_run == SR_W'(SYNC_WORDS - 1));
  assign state      = st;

  // Sequencer: one register block holding state, counters and all outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      st                 <= S_IDLE;
      rst_cnt            <= '0;
      sync_run           <= '0;
      sync_cyc           <= '0;
      words_seen         <= '0;
      window_q           <= '0;
      thresh_q           <= '0;
      channel_reset      <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      sync_fail          <= 1'b0;
      threshold_exceeded <= 1'b0;
      total_errors       <= '0;
      total_bits         <= '0;
    end else begin
      // Sticky compare against the registered total; lags the total by one cycle
      threshold_exceeded <= threshold_exceeded | (total_errors > thresh_q);
      case (st)
        S_IDLE, S_DONE: begin
          if (start) begin
            st                 <= S_CHRST;
            busy               <= 1'b1;
            channel_reset      <= 1'b1;
            done               <= 1'b0;
            sync_fail          <= 1'b0;
            threshold_exceeded <= 1'b0;
            total_errors       <= '0;
            total_bits         <= '0;
            window_q           <= (window_words == '0) ? CNT_W'(1) : window_words;
            thresh_q           <= err_threshold;
            rst_cnt            <= '0;
          end
        end
        S_CHRST: begin
          if (abort) begin
            st            <= S_IDLE;
            busy          <= 1'b0;
            channel_reset <= 1'b0;
          end else if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            st            <= S_SYNC;
            channel_reset <= 1'b0;
            sync_run      <= '0;
            sync_cyc      <= '0;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        S_SYNC: begin
          if (abort) begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end else begin
            sync_cyc <= sync_cyc + TO_W'(1);
            if (sync_hit) begin
              st         <= S_MEASURE;
              sync_run   <= '0;
              words_seen <= '0;
            end else if (clean_word) begin
              sync_run <= sync_run + SR_W'(1);
            end else if (word_valid) begin
              sync_run <= '0;
            end
            // Sync on the final allowed cycle takes priority over timeout
            if (!sync_hit && sync_cyc == TO_W'(SYNC_TIMEOUT - 1)) begin
              st        <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              sync_fail <= 1'b1;
            end
          end
        end
        S_MEASURE: begin
          if (abort) begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end else if (word_valid) begin
            total_errors <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
            total_bits   <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
            words_seen   <= words_seen + CNT_W'(1);
            if (words_seen + CNT_W'(1) == window_q) begin
              st   <= S_DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        default: begin
          st   <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bert_test_sequencer.sv
// Directed bench for bert_test_sequencer: run sequencing, sync restart, timeout, threshold,
// abort with simultaneous start, and zero-length window with an ignored busy start.
module tb_bert_test_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] window_words;
  logic [31:0] err_threshold;
  logic        word_valid;
  logic [7:0]  error;
  logic        channel_reset;
  logic        busy;
  logic        done;
  logic        sync_fail;
  logic        threshold_exceeded;
  logic [31:0] total_errors;
  logic [31:0] total_bits;
  logic [2:0]  state;

  int compared   = 0;
  int mismatched = 0;

  bert_test_sequencer dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .abort              (abort),
    .window_words       (window_words),
    .err_threshold      (err_threshold),
    .word_valid         (word_valid),
    .error              (error),
    .channel_reset      (channel_reset),
    .busy               (busy),
    .done               (done),
    .sync_fail          (sync_fail),
    .threshold_exceeded (threshold_exceeded),
    .total_errors       (total_errors),
    .total_bits         (total_bits),
    .state              (state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issue a start and step through the four channel-reset cycles into SYNC
  task automatic start_run(input logic [31:0] win, input logic [31:0] thr);
    start = 1'b1; window_words = win; err_threshold = thr;
    tick();
    start = 1'b0;
    check("run_state_chrst", 32'(state), 32'd1);
    check("run_chrst_high", 32'(channel_reset), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check("run_chrst_last", 32'(channel_reset), 32'd1);
    tick();
    check("run_state_sync", 32'(state), 32'd2);
    check("run_chrst_low", 32'(channel_reset), 32'd0);
  endtask

  task automatic words(input int n, input logic [7:0] e);
    word_valid = 1'b1; error = e;
    for (int i = 0; i < n; i++) tick();
    word_valid = 1'b0; error = 8'h00;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; window_words = '0; err_threshold = '0;
    word_valid = 1'b0; error = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_outputs", {27'd0, channel_reset, busy, done, sync_fail, threshold_exceeded}, 32'd0);
    check("rst_totals", total_errors | total_bits, 32'd0);

    // Basic run: window 4, errors 0x03 per word
    start_run(32'd4, 32'd100);
    check("t1_busy", 32'(busy), 32'd1);
    words(15, 8'h00);
    check("t1_still_sync", 32'(state), 32'd2);
    words(1, 8'h00);
    check("t1_measure", 32'(state), 32'd3);
    check("t1_no_sync_bits", total_bits, 32'd0);
    words(3, 8'h03);
    check("t1_mid_state", 32'(state), 32'd3);
    words(1, 8'h03);
    check("t1_done_state", 32'(state), 32'd4);
    check("t1_errors", total_errors, 32'd8);
    check("t1_bits", total_bits, 32'd32);
    check("t1_flags", {29'd0, done, busy, threshold_exceeded}, 32'b100);

    // Sync restarts after an errored word
    start_run(32'd1, 32'd100);
    check("t2_cleared", total_errors | total_bits, 32'd0);
    words(10, 8'h00);
    words(1, 8'h01);
    words(15, 8'h00);
    check("t2_not_synced", 32'(state), 32'd2);
    words(1, 8'h00);
    check("t2_synced", 32'(state), 32'd3);
    check("t2_no_sync_errors", total_errors, 32'd0);
    words(1, 8'h81);
    check("t2_done", 32'(state), 32'd4);
    check("t2_errors", total_errors, 32'd2);
    check("t2_bits", total_bits, 32'd8);

    // Sync timeout with every word errored
    start_run(32'd4, 32'd100);
    words(1023, 8'hFF);
    check("t3_pre_timeout", 32'(state), 32'd2);
    check("t3_pre_fail", 32'(sync_fail), 32'd0);
    words(1, 8'hFF);
    check("t3_state", 32'(state), 32'd4);
    check("t3_flags", {29'd0, sync_fail, done, busy}, 32'b110);
    check("t3_bits", total_bits, 32'd0);

    // Threshold crossing lags the total by one cycle
    start_run(32'd3, 32'd5);
    check("t4_syncfail_clr", 32'(sync_fail), 32'd0);
    words(16, 8'h00);
    words(1, 8'h0F);
    check("t4_err1", total_errors, 32'd4);
    words(1, 8'h0F);
    check("t4_err2", total_errors, 32'd8);
    check("t4_thr_lo", 32'(threshold_exceeded), 32'd0);
    words(1, 8'h0F);
    check("t4_err3", total_errors, 32'd12);
    check("t4_thr_hi", 32'(threshold_exceeded), 32'd1);
    check("t4_bits", total_bits, 32'd24);
    check("t4_done", 32'(done), 32'd1);

    // Abort mid-measure with start in the same cycle
    start_run(32'd4, 32'd100);
    words(16, 8'h00);
    words(2, 8'h01);
    abort = 1'b1; start = 1'b1; word_valid = 1'b1; error = 8'hFF;
    tick();
    abort = 1'b0; start = 1'b0; word_valid = 1'b0; error = 8'h00;
    check("t5_state", 32'(state), 32'd0);
    check("t5_flags", {29'd0, done, busy, channel_reset}, 32'd0);
    check("t5_errors", total_errors, 32'd2);
    check("t5_bits", total_bits, 32'd16);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle_abort", 32'(state), 32'd0);

    // Zero window becomes one word; a start while busy is ignored
    start_run(32'd0, 32'd100);
    check("t6_cleared", total_errors | total_bits, 32'd0);
    start = 1'b1; window_words = 32'd5;
    tick();
    start = 1'b0;
    check("t6_busy_start", 32'(state), 32'd2);
    words(16, 8'h00);
    check("t6_measure", 32'(state), 32'd3);
    words(1, 8'h00);
    check("t6_done", 32'(state), 32'd4);
    check("t6_bits", total_bits, 32'd8);
    check("t6_errors", total_errors, 32'd0);

    // Reset mid-run
    start_run(32'd4, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_state", 32'(state), 32'd0);
    check("t7_outputs", {27'd0, channel_reset, busy, done, sync_fail, threshold_exceeded}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
